// File: rtl/prga_if.sv
// prga_if: start handshake plus the S, CT and PT memory ports of the ARC4 PRGA engine.
interface prga_if;
    logic       en;
    logic       rdy;
    logic [7:0] s_addr;
    logic [7:0] s_rddata;
    logic [7:0] s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr;
    logic [7:0] ct_rddata;
    logic [7:0] pt_addr;
    logic [7:0] pt_wrdata;
    logic       pt_wren;

    // Engine side: accepts en, drives the memory ports.
    modport slave (
        input  en, s_rddata, ct_rddata,
        output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );

    // Caller/memory side.
    modport master (
        output en, s_rddata, ct_rddata,
        input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren
    );
endinterface

// File: rtl/prga.sv
// prga: ARC4 keystream generator; decrypts length-prefixed CT into PT, swapping S in place.
// All outputs except pt_wrdata are registered; each is loaded on the transition into
// the state that presents it, so it is valid for exactly that state.
module prga (
    input logic   clk,
    input logic   rst_n,
    prga_if.slave bus
);

    typedef enum logic [3:0] {
        StIdle, StRdLen, StWrLen, StRdSi, StCapSi, StRdSj,
        StCapSj, StWrSi, StWrSj, StRdPad, StWrPt
    } state_t;

    state_t     state_q;
    logic [7:0] i_q, j_q, k_q, len_q, si_q, sj_q;
    logic       rdy_q, s_wren_q, pt_wren_q;
    logic [7:0] s_addr_q, s_wrdata_q, ct_addr_q, pt_addr_q;
    logic [7:0] pt_wrdata_c;

    // Sequencer: state, byte registers and registered outputs for the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            k_q        <= 8'd0;
            len_q      <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            rdy_q      <= 1'b1;
            s_addr_q   <= 8'd0;
            s_wrdata_q <= 8'd0;
            s_wren_q   <= 1'b0;
            ct_addr_q  <= 8'd0;
            pt_addr_q  <= 8'd0;
            pt_wren_q  <= 1'b0;
        end else begin
            rdy_q      <= 1'b0;
            s_addr_q   <= 8'd0;
            s_wrdata_q <= 8'd0;
            s_wren_q   <= 1'b0;
            ct_addr_q  <= 8'd0;
            pt_addr_q  <= 8'd0;
            pt_wren_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.en) begin
                        i_q     <= 8'd0;
                        j_q     <= 8'd0;
                        k_q     <= 8'd1;
                        state_q <= StRdLen;    // ct_addr stays 0 for the length read
                    end else begin
                        rdy_q   <= 1'b1;
                    end
                end
                StRdLen: begin
                    pt_wren_q <= 1'b1;         // pt[0] <= length, pt_addr 0
                    state_q   <= StWrLen;
                end
                StWrLen: begin
                    len_q <= bus.ct_rddata;
                    if (bus.ct_rddata == 8'd0) begin
                        rdy_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        i_q      <= 8'd1;
                        s_addr_q <= 8'd1;
                        state_q  <= StRdSi;
                    end
                end
                StRdSi: state_q <= StCapSi;
                StCapSi: begin
                    si_q     <= bus.s_rddata;
                    j_q      <= j_q + bus.s_rddata;
                    s_addr_q <= j_q + bus.s_rddata;
                    state_q  <= StRdSj;
                end
                StRdSj: state_q <= StCapSj;
                StCapSj: begin
                    sj_q       <= bus.s_rddata;
                    s_addr_q   <= i_q;
                    s_wrdata_q <= bus.s_rddata;
                    s_wren_q   <= 1'b1;
                    state_q    <= StWrSi;
                end
                StWrSi: begin
                    s_addr_q   <= j_q;
                    s_wrdata_q <= si_q;
                    s_wren_q   <= 1'b1;
                    state_q    <= StWrSj;
                end
                StWrSj: begin
                    s_addr_q  <= si_q + sj_q;
                    ct_addr_q <= k_q;
                    state_q   <= StRdPad;
                end
                StRdPad: begin
                    pt_addr_q <= k_q;
                    pt_wren_q <= 1'b1;
                    state_q   <= StWrPt;
                end
                StWrPt: begin
                    if (k_q == len_q) begin
                        rdy_q   <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        k_q      <= k_q + 8'd1;
                        i_q      <= i_q + 8'd1;
                        s_addr_q <= i_q + 8'd1;
                        state_q  <= StRdSi;
                    end
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // PT write data comes straight from the memory read ports in the two write states.
    always_comb begin
        pt_wrdata_c = 8'd0;
        case (state_q)
            StWrLen: pt_wrdata_c = bus.ct_rddata;
            StWrPt:  pt_wrdata_c = bus.s_rddata ^ bus.ct_rddata;
            default: pt_wrdata_c = 8'd0;
        endcase
    end

    assign bus.rdy       = rdy_q;
    assign bus.s_addr    = s_addr_q;
    assign bus.s_wrdata  = s_wrdata_q;
    assign bus.s_wren    = s_wren_q;
    assign bus.ct_addr   = ct_addr_q;
    assign bus.pt_addr   = pt_addr_q;
    assign bus.pt_wrdata = pt_wrdata_c;
    assign bus.pt_wren   = pt_wren_q;

endmodule

// File: tb/tb_prga.sv
// tb_prga: directed scenarios with synchronous S/CT/PT memory models and a PT-write scoreboard.
module tb_prga;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } pt_item_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt = 0;
    int   swren_cnt = 0;

    logic [7:0] s_mem  [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] s_model[256];
    pt_item_t   exp_q[$];

    prga_if bus ();

    prga dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memories with 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
        bus.s_rddata  <= s_mem[bus.s_addr];
        bus.ct_rddata <= ct_mem[bus.ct_addr];
        if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: busy/write counters and scoreboard pop on every PT write.
    always @(negedge clk) begin
        pt_item_t it;
        if (!bus.rdy) busy_cnt <= busy_cnt + 1;
        if (bus.s_wren) swren_cnt <= swren_cnt + 1;
        if (bus.pt_wren) begin
            check("pt_write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                it = exp_q.pop_front();
                check("pt_addr", 32'(bus.pt_addr), 32'(it.addr));
                check("pt_data", 32'(bus.pt_wrdata), 32'(it.data));
            end
        end
    end

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
        for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hAA;
        #1;
    endtask

    task automatic load_ct3(input logic [7:0] l, input logic [7:0] c1, input logic [7:0] c2);
        ct_mem[0] <= l;
        ct_mem[1] <= c1;
        ct_mem[2] <= c2;
        #1;
    endtask

    // Reference ARC4 PRGA over the current memory contents; queues every PT write.
    task automatic push_expected();
        logic [7:0] s[256];
        logic [7:0] i, j, t, len;
        for (int x = 0; x < 256; x++) s[x] = s_mem[x];
        len = ct_mem[0];
        exp_q.push_back({8'd0, len});
        i = 8'd0;
        j = 8'd0;
        for (int k = 1; k <= int'(len); k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_q.push_back({8'(k), s[t] ^ ct_mem[k]});
        end
        for (int x = 0; x < 256; x++) s_model[x] = s[x];
    endtask

    // Start a run, optionally pulse en while busy, then wait (bounded) for rdy.
    task automatic run(input int pulses, output int busy, output int swr);
        int b0, w0;
        @(negedge clk);
        b0 = busy_cnt;
        w0 = swren_cnt;
        bus.en = 1'b1;
        @(negedge clk);
        bus.en = 1'b0;
        for (int p = 0; p < pulses; p++) begin
            @(negedge clk) bus.en = 1'b1;
            @(negedge clk) bus.en = 1'b0;
        end
        for (int n = 0; n < 5000 && !bus.rdy; n++) @(negedge clk);
        check("rdy_return", 32'(bus.rdy), 32'd1);
        busy = busy_cnt - b0;
        swr  = swren_cnt - w0;
    endtask

    initial begin
        int busy, swr, diffs, cnt;
        logic [7:0] key[3];
        logic [7:0] j, t;

        rst_n  = 1'b0;
        bus.en = 1'b0;
        load_identity();
        repeat (3) @(negedge clk);
        check("reset_rdy", 32'(bus.rdy), 32'd1);
        check("reset_s_wren", 32'(bus.s_wren), 32'd0);
        check("reset_pt_wren", 32'(bus.pt_wren), 32'd0);
        check("reset_addrs", {8'd0, bus.s_addr, bus.ct_addr, bus.pt_addr}, 32'd0);
        rst_n = 1'b1;

        // Identity S, one byte.
        load_ct3(8'd1, 8'h55, 8'h00);
        push_expected();
        run(0, busy, swr);
        check("t1_busy", 32'(busy), 32'd10);
        check("t1_pt0", 32'(pt_mem[0]), 32'd1);
        check("t1_pt1", 32'(pt_mem[1]), 32'h57);
        diffs = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== 8'(x)) diffs++;
        check("t1_s_unchanged", 32'(diffs), 32'd0);
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Identity S, two bytes.
        load_identity();
        load_ct3(8'd2, 8'h55, 8'h00);
        push_expected();
        run(0, busy, swr);
        check("t2_busy", 32'(busy), 32'd18);
        check("t2_pt1", 32'(pt_mem[1]), 32'h57);
        check("t2_pt2", 32'(pt_mem[2]), 32'h05);
        check("t2_s2", 32'(s_mem[2]), 32'd3);
        check("t2_s3", 32'(s_mem[3]), 32'd2);
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero length.
        load_identity();
        load_ct3(8'd0, 8'h11, 8'h22);
        push_expected();
        run(0, busy, swr);
        check("t3_busy", 32'(busy), 32'd2);
        check("t3_pt0", 32'(pt_mem[0]), 32'd0);
        check("t3_no_s_wren", 32'(swr), 32'd0);
        check("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in WR_SI of the third byte of an L=10 run.
        load_identity();
        ct_mem[0] <= 8'd10;
        for (int x = 1; x <= 10; x++) ct_mem[x] <= 8'($urandom_range(0, 255));
        #1;
        push_expected();
        @(negedge clk) bus.en = 1'b1;
        @(negedge clk) bus.en = 1'b0;
        cnt = 0;
        for (int n = 0; n < 200 && cnt < 5; n++) begin
            @(negedge clk);
            if (bus.s_wren) cnt++;
        end
        check("t4_reached_wr_si", 32'(cnt), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_rdy", 32'(bus.rdy), 32'd1);
        check("t4_rst_strobes", {29'd0, bus.s_wren, bus.pt_wren, 1'b0}, 32'd0);
        check("t4_rst_addrs", {8'd0, bus.s_addr, bus.ct_addr, bus.pt_addr}, 32'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        load_identity();
        push_expected();
        run(0, busy, swr);
        check("t4_busy", 32'(busy), 32'd82);
        check("t4_pt0", 32'(pt_mem[0]), 32'd10);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // en pulsed repeatedly while busy: no restart.
        load_identity();
        load_ct3(8'd2, 8'h55, 8'h00);
        push_expected();
        run(7, busy, swr);
        check("t5_busy", 32'(busy), 32'd18);
        check("t5_pt1", 32'(pt_mem[1]), 32'h57);
        check("t5_pt2", 32'(pt_mem[2]), 32'h05);
        check("t5_s2", 32'(s_mem[2]), 32'd3);
        check("t5_s3", 32'(s_mem[3]), 32'd2);
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Golden: S after KSA with key 00 03 3C, L=255.
        key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
        for (int x = 0; x < 256; x++) s_model[x] = 8'(x);
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + s_model[x] + key[x % 3];
            t = s_model[x]; s_model[x] = s_model[j]; s_model[j] = t;
        end
        for (int x = 0; x < 256; x++) s_mem[x] <= s_model[x];
        ct_mem[0] <= 8'd255;
        for (int x = 1; x < 256; x++) ct_mem[x] <= 8'($urandom_range(0, 255));
        #1;
        push_expected();
        run(0, busy, swr);
        check("t6_busy", 32'(busy), 32'd2042);
        check("t6_pt0", 32'(pt_mem[0]), 32'd255);
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
        diffs = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== s_model[x]) diffs++;
        check("t6_s_final", 32'(diffs), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
